// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encoding, limits and phase helper for the clock divider
package clk_div_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MIN_RATIO = 2;

    // High phase is the ceiling half so the low phase is never empty for N>=2.
    function automatic int unsigned hi_len(input int unsigned n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - ratio configuration handshake between a host and the divider
interface clk_div_ctrl_if #(
    parameter int W = 8
) ();
    logic         cfg_valid;
    logic [W-1:0] cfg_ratio;
    logic         cfg_ready;
    logic         cfg_err;

    modport master (
        output cfg_valid,
        output cfg_ratio,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ratio,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter with registered clk_out/tick and boundary strobe
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         run_i,
    input  logic         en_i,
    input  logic [W-1:0] ratio_i,
    output logic         boundary_o,
    output logic         clk_out_o,
    output logic         tick_o
);
    logic [W-1:0] cnt_q, cnt_d, cnt_inc, hi;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_inc    = cnt_q + W'(1);
        hi         = W'(hi_len(32'(ratio_i)));
        boundary_o = run_i && (cnt_q == ratio_i - W'(1));
        cnt_d      = '0;
        clk_out_d  = 1'b0;
        tick_d     = 1'b0;
        // A fresh period always opens high, whatever ratio it was loaded with.
        if (start_i || (boundary_o && en_i)) begin
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
        end else if (run_i && !boundary_o) begin
            cnt_d     = cnt_inc;
            clk_out_d = (cnt_inc < hi);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable divider: ratio handshake, pending ratio and run/idle sequencing
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int W         = 8,
    parameter int DEF_RATIO = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    clk_div_ctrl_if.slave  cfg,
    output logic [W-1:0]   ratio_o,
    output logic           clk_out,
    output logic           tick,
    output logic           busy
);
    state_e       state_q, state_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;
    logic         cfg_ready_q, cfg_ready_d;
    logic         cfg_err_q, cfg_err_d;
    logic         boundary, xfer;

    clk_div_core #(.W(W)) u_core (
        .clk        (clk),
        .rst        (rst),
        .start_i    (state_q == ST_IDLE && en),
        .run_i      (state_q == ST_RUN),
        .en_i       (en),
        .ratio_i    (ratio_q),
        .boundary_o (boundary),
        .clk_out_o  (clk_out),
        .tick_o     (tick)
    );

    always_comb begin
        state_d      = state_q;
        ratio_d      = ratio_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = 1'b0;
        xfer         = cfg.cfg_valid && cfg_ready_q;

        case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN:  if (boundary && !en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (boundary && pend_valid_q) begin
            ratio_d      = pend_q;
            pend_valid_d = 1'b0;
        end

        // Ready implies nothing pending, so a boundary-cycle transfer never collides with apply.
        if (xfer) begin
            if (cfg.cfg_ratio < W'(MIN_RATIO)) begin
                cfg_err_d = 1'b1;
            end else if (state_q == ST_IDLE) begin
                ratio_d = cfg.cfg_ratio;
            end else begin
                pend_d       = cfg.cfg_ratio;
                pend_valid_d = 1'b1;
            end
        end

        cfg_ready_d = !pend_valid_d && !(boundary && pend_valid_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ratio_q      <= W'(DEF_RATIO);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cfg_ready_q  <= 1'b1;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ratio_q      <= ratio_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cfg_ready_q  <= cfg_ready_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign ratio_o       = ratio_q;
    assign busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;
    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] ratio_o;
    logic       clk_out;
    logic       tick;
    logic       busy;
    int         checks;
    int         errors;

    clk_div_ctrl_if #(.W(8)) cfg_if ();

    clk_div_ctrl #(.W(8), .DEF_RATIO(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg     (cfg_if),
        .ratio_o (ratio_o),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts on the first high cycle of a period, ends on the first cycle after the last period.
    task automatic wave(input string tag, input int hi, input int lo, input int periods);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < hi + lo; i++) begin
                chk1({tag, "_clk"}, clk_out, (i < hi));
                chk1({tag, "_tick"}, tick, (i == 0));
                step();
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        en = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ratio = 8'd0;
        step();
        step();
        chk1("rst_clk", clk_out, 1'b0);
        chk1("rst_tick", tick, 1'b0);
        chk1("rst_ready", cfg_if.cfg_ready, 1'b1);
        chk1("rst_err", cfg_if.cfg_err, 1'b0);
        chkw("rst_ratio", ratio_o, 8'd3);
        chk1("rst_busy", busy, 1'b0);

        rst = 1'b1;
        step();
        chk1("run_busy", busy, 1'b1);
        wave("n3", 2, 1, 3);

        // Ratio 5 offered at cnt=0 of an N=3 period
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ratio = 8'd5;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk1("pend_ready1", cfg_if.cfg_ready, 1'b0);
        chk1("pend_clk1", clk_out, 1'b1);
        chkw("pend_ratio1", ratio_o, 8'd3);
        step();
        chk1("pend_ready2", cfg_if.cfg_ready, 1'b0);
        chk1("pend_clk2", clk_out, 1'b0);
        chkw("pend_ratio2", ratio_o, 8'd3);
        step();
        chkw("wrap_ratio", ratio_o, 8'd5);
        chk1("wrap_ready", cfg_if.cfg_ready, 1'b0);
        chk1("wrap_tick", tick, 1'b1);
        chk1("wrap_clk", clk_out, 1'b1);
        step();
        chk1("after_ready", cfg_if.cfg_ready, 1'b1);
        chk1("after_tick", tick, 1'b0);
        chk1("after_clk", clk_out, 1'b1);
        step();
        chk1("n5a_clk2", clk_out, 1'b1);
        step();
        chk1("n5a_clk3", clk_out, 1'b0);
        step();
        chk1("n5a_clk4", clk_out, 1'b0);
        step();
        wave("n5", 3, 2, 1);

        // Rejected ratios 1 then 0 leave the running divider alone
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ratio = 8'd1;
        step();
        chk1("err1_pulse", cfg_if.cfg_err, 1'b1);
        chk1("err1_ready", cfg_if.cfg_ready, 1'b1);
        chk1("err1_clk", clk_out, 1'b1);
        cfg_if.cfg_ratio = 8'd0;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk1("err0_pulse", cfg_if.cfg_err, 1'b1);
        chk1("err0_clk", clk_out, 1'b1);
        step();
        chk1("err_clear", cfg_if.cfg_err, 1'b0);
        chk1("err_clk3", clk_out, 1'b0);
        chkw("err_ratio", ratio_o, 8'd5);
        step();
        step();
        wave("n5_post_err", 3, 2, 1);

        // Disable at cnt=0 of N=5: period completes then IDLE
        en = 1'b0;
        step();
        step();
        step();
        step();
        chk1("dis_busy_last", busy, 1'b1);
        step();
        chk1("dis_idle_clk", clk_out, 1'b0);
        chk1("dis_idle_busy", busy, 1'b0);

        // IDLE configuration applies immediately
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ratio = 8'd4;
        step();
        cfg_if.cfg_valid = 1'b0;
        chkw("idle_ratio", ratio_o, 8'd4);
        chk1("idle_ready", cfg_if.cfg_ready, 1'b1);
        chk1("idle_clk", clk_out, 1'b0);
        en = 1'b1;
        step();
        wave("n4", 2, 2, 2);

        // Drop en at cnt=1 of N=4
        step();
        chk1("drop_clk1", clk_out, 1'b1);
        en = 1'b0;
        step();
        chk1("drop_clk2", clk_out, 1'b0);
        step();
        chk1("drop_clk3", clk_out, 1'b0);
        chk1("drop_busy3", busy, 1'b1);
        step();
        chk1("drop_idle_clk", clk_out, 1'b0);
        chk1("drop_idle_busy", busy, 1'b0);
        chk1("drop_idle_tick", tick, 1'b0);

        // en dropped at cnt=1 and re-raised at cnt=2: no gap
        en = 1'b1;
        step();
        chk1("rerun_tick", tick, 1'b1);
        step();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        step();
        chk1("nogap_busy", busy, 1'b1);
        wave("n4_nogap", 2, 2, 1);

        // Ratio 2 via pending path
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ratio = 8'd2;
        step();
        cfg_if.cfg_valid = 1'b0;
        step();
        step();
        step();
        chkw("n2_ratio", ratio_o, 8'd2);
        wave("n2", 1, 1, 3);

        // N=5 running with pending 3, reset at cnt=2
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ratio = 8'd5;
        step();
        cfg_if.cfg_valid = 1'b0;
        step();
        chkw("pre_rst_ratio", ratio_o, 8'd5);
        step();
        chk1("pre_rst_ready", cfg_if.cfg_ready, 1'b1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ratio = 8'd3;
        step();
        cfg_if.cfg_valid = 1'b0;
        chk1("pre_rst_pend", cfg_if.cfg_ready, 1'b0);
        rst = 1'b0;
        step();
        chk1("mid_rst_clk", clk_out, 1'b0);
        chk1("mid_rst_tick", tick, 1'b0);
        chkw("mid_rst_ratio", ratio_o, 8'd3);
        chk1("mid_rst_ready", cfg_if.cfg_ready, 1'b1);
        chk1("mid_rst_busy", busy, 1'b0);
        rst = 1'b1;
        step();
        wave("n3_after_rst", 2, 1, 2);
        chk1("post_rst_ready", cfg_if.cfg_ready, 1'b1);
        chkw("post_rst_ratio", ratio_o, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable integer clock divider with a glitch-free ratio-change and enable/disable sequencer. It generates a registered divided clock (clk_out) from clk and accepts new divide ratios over a valid/ready handshake. Ratio changes and disables take effect only at a period boundary, so no runt pulses reach downstream consumers. It is the configurable successor to the fixed-ratio dividers in the clock-divider library.

Parameters:
W, 8, width of divide ratio and period counter
DEF_RATIO, 3, ratio loaded at reset; must be 2..2^W-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
en  input  1  divider enable; level-sensitive
cfg_valid  input  1  new ratio offered
cfg_ratio  input  W  requested divide ratio N
cfg_ready  output  1  controller can accept a ratio
cfg_err  output  1  one-cycle pulse: offered ratio rejected (N<2)
ratio_o  output  W  currently active ratio
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle strobe, coincident with each clk_out rising cycle
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, cnt=0, active ratio=DEF_RATIO, no pending ratio, clk_out=0, tick=0, cfg_err=0, cfg_ready=1, busy=0.
- Waveform for active ratio N: high phase hi=N-floor(N/2) (ceil), low phase lo=floor(N/2). N=2 gives 1,0. N=3 gives 1,1,0. Low phase always >=1 cycle.
- Counter cnt runs 0..N-1 and is registered. clk_out=1 while cnt<hi.
- States:
  - IDLE: clk_out=0. When en=1, next cycle goes to RUN with cnt=0, clk_out=1, tick=1.
  - RUN, cnt<N-1: cnt<=cnt+1, clk_out<=(cnt+1<hi).
  - RUN, cnt==N-1 (boundary): apply the pending ratio if present. If en=1, cnt<=0, clk_out<=1, tick<=1. If en=0, go to DRAIN-exit, which means IDLE next cycle with clk_out=0.
- Disable: en may drop anywhere. The current period completes, then the block enters IDLE. If en returns high before the boundary, the divider continues seamlessly with no gap.
- Config handshake: a transfer occurs when cfg_valid&&cfg_ready.
  - cfg_ratio<2: cfg_err=1 the next cycle for one cycle. Ratio and pending state are unchanged. cfg_ready stays 1.
  - Valid ratio in IDLE: active ratio<=cfg_ratio next cycle. cfg_ready stays 1.
  - Valid ratio in RUN: stored as pending. cfg_ready=0 from the next cycle until the boundary applies it. cfg_ready=1 again the cycle after application.
  - The first period after application uses the new N. ratio_o updates in the same cycle that cnt wraps to 0.
- Simultaneous events:
  - Transfer accepted in the boundary cycle while in RUN: becomes pending for the next boundary, not the current one.
  - en=0 together with a pending ratio: the ratio is applied at the boundary, then IDLE.
- Reset mid-operation: immediate return to the reset values above. Any pending ratio is discarded and clk_out=0 on the next edge.
- All outputs are registered. No combinational path from inputs to outputs except cfg_ready, which is a register.

Decomposition:
- Shared package clk_div_pkg holds:
  - state encoding (IDLE, RUN)
  - MIN_RATIO=2
  - function hi_len(N)=N-(N>>1)
- One natural sub-module, clk_div_core: counter plus clk_out/tick generation with a load-at-boundary ratio input and a boundary strobe output.
- Handshake, pending register and FSM stay in clk_div_ctrl.

Test Plan:
- Reset: hold rst=0 for 2 cycles with en=1 → clk_out=0, tick=0, cfg_ready=1, ratio_o=3, busy=0. Release and keep en=1 → clk_out pattern 1,1,0 repeating; tick every 3rd cycle, aligned to the 1st high cycle.
- In IDLE, send cfg_ratio=4, then en=1 → ratio_o=4 next cycle; clk_out 1,1,0,0 repeating. Send ratio 2 → 1,0 repeating.
- Running N=3, at cnt=0 send cfg_ratio=5 → cfg_ready low until the boundary. Current period finishes 1,1,0. Next period is 1,1,1,0,0. ratio_o=5 at the wrap cycle. cfg_ready high the cycle after.
- Send cfg_ratio=1, then 0 → cfg_err pulses one cycle each; ratio_o unchanged; waveform undisturbed.
- N=4, drop en at cnt=1 → period completes 1,1,0,0, then clk_out=0 and busy=0. Repeat with en re-raised at cnt=2 → no gap, next period starts at once.
- N=5 running with pending ratio 3, assert rst=0 at cnt=2 → next edge clk_out=0, ratio_o=3 (DEF), cfg_ready=1, pending discarded. After release with en=1 → 1,1,0.
